// File: rtl/autoenc_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, state encoding and instruction field positions.
package autoenc_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_EXEC = 4'h1;
    localparam logic [3:0] OP_JMP  = 4'h2;
    localparam logic [3:0] OP_LOOP = 4'h3;
    localparam logic [3:0] OP_DJNZ = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_ISSUE  = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int OPND_MSB = 11;
    localparam int OPND_LSB = 0;
    localparam int CODE_MSB = 11;
    localparam int CODE_LSB = 8;
    localparam int ARG_MSB  = 7;
    localparam int ARG_LSB  = 0;

endpackage

// File: rtl/instr_sequencer.sv
// Program sequencer: fetches from a registered instruction memory, runs NOP/JMP/LOOP/DJNZ/HALT locally (2 cycles each)
// and issues EXEC micro-ops over valid/ready, holding op_valid/op_code/op_arg stable until op_ready.
module instr_sequencer
    import autoenc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 512,
    parameter int PC_WIDTH   = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [15:0]           counter,
    input  logic [DATA_WIDTH-1:0] instructCode,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [3:0]            op_code,
    output logic [7:0]            op_arg,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [11:0]           r_loop_cnt;
    logic                  r_illegal;
    logic [3:0]            r_op_code;
    logic [7:0]            r_op_arg;

    logic [3:0]            w_opcode;
    logic [11:0]           w_operand;
    logic [PC_WIDTH-1:0]   w_target;
    logic [PC_WIDTH-1:0]   w_pc_inc;

    assign w_opcode  = instructCode[OPC_MSB:OPC_LSB];
    assign w_operand = instructCode[OPND_MSB:OPND_LSB];
    assign w_target  = w_operand[PC_WIDTH-1:0];

    // Sequential pc wraps at DEPTH even when DEPTH is not a power of two.
    always_comb begin
        w_pc_inc = r_pc + PC_WIDTH'(1);
        if (int'(w_pc_inc) >= DEPTH) begin
            w_pc_inc = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_FETCH;
                ST_FETCH:         w_state_nxt = ST_DECODE;
                ST_DECODE: begin
                    case (w_opcode)
                        OP_EXEC: w_state_nxt = ST_ISSUE;
                        OP_HALT: w_state_nxt = ST_DONE;
                        default: w_state_nxt = ST_FETCH;
                    endcase
                end
                ST_ISSUE:         if (op_ready) w_state_nxt = ST_FETCH;
                default:          w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (r_state == ST_FETCH) || (r_state == ST_DECODE) || (r_state == ST_ISSUE);
        done     = (r_state == ST_DONE);
        op_valid = (r_state == ST_ISSUE);
        op_code  = r_op_code;
        op_arg   = r_op_arg;
        illegal  = r_illegal;
        counter  = {{(16-PC_WIDTH){1'b0}}, r_pc};
    end

    // Abort clears pc only; loop count and the illegal flag survive for post-mortem.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= '0;
            r_loop_cnt <= '0;
            r_illegal  <= 1'b0;
            r_op_code  <= '0;
            r_op_arg   <= '0;
        end else if (abort) begin
            r_pc <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_pc       <= '0;
                        r_loop_cnt <= '0;
                        r_illegal  <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    case (w_opcode)
                        OP_NOP:  r_pc <= w_pc_inc;
                        OP_EXEC: begin
                            r_op_code <= instructCode[CODE_MSB:CODE_LSB];
                            r_op_arg  <= instructCode[ARG_MSB:ARG_LSB];
                        end
                        OP_JMP:  r_pc <= w_target;
                        OP_LOOP: begin
                            r_loop_cnt <= w_operand;
                            r_pc       <= w_pc_inc;
                        end
                        OP_DJNZ: begin
                            if (r_loop_cnt > 12'd1) begin
                                r_loop_cnt <= r_loop_cnt - 12'd1;
                                r_pc       <= w_target;
                            end else begin
                                r_loop_cnt <= '0;
                                r_pc       <= w_pc_inc;
                            end
                        end
                        OP_HALT: r_pc <= r_pc;
                        default: begin
                            r_illegal <= 1'b1;
                            r_pc      <= w_pc_inc;
                        end
                    endcase
                end
                ST_ISSUE: if (op_ready) r_pc <= w_pc_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a registered memory model and a micro-op scoreboard.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, op_ready;
    logic [15:0] counter, instructCode;
    logic        op_valid, busy, done, illegal;
    logic [3:0]  op_code;
    logic [7:0]  op_arg;

    logic [15:0] mem [0:511];
    logic [11:0] sb_q [$];
    int          checks = 0;
    int          errors = 0;
    int          hs_cnt = 0;

    instr_sequencer #(.DATA_WIDTH(16), .DEPTH(512), .PC_WIDTH(9)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .counter(counter), .instructCode(instructCode),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_arg(op_arg),
        .busy(busy), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) instructCode <= mem[counter[8:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted micro-op must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        logic [11:0] e;
        if (rst_n && op_valid && op_ready) begin
            hs_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%0h%02h expected=none", op_code, op_arg);
            end else begin
                e = sb_q.pop_front();
                chk("sb_op_code", {28'd0, op_code}, {28'd0, e[11:8]});
                chk("sb_op_arg", {24'd0, op_arg}, {24'd0, e[7:0]});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    endtask

    task automatic load_loop_prog();
        clear_mem();
        mem[0] = 16'h3003; mem[1] = 16'h1100; mem[2] = 16'h4001; mem[3] = 16'hF000;
    endtask

    int exp_ctr [5] = '{0, 0, 3, 3, 3};
    int hs_base;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; op_ready = 1'b0;
        clear_mem();
        step(2);
        chk("rst_counter", counter, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_op_code", op_code, 0);
        chk("rst_op_arg", op_arg, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_illegal", illegal, 0);
        rst_n = 1'b1;
        step(1);

        // EXEC then HALT with delayed ready
        mem[0] = 16'h1A05; mem[1] = 16'hF000;
        sb_q.push_back(12'hA05);
        start = 1'b1; step(1); start = 1'b0;
        step(2);
        chk("t1_op_valid", op_valid, 1);
        chk("t1_op_code", op_code, 4'hA);
        chk("t1_op_arg", op_arg, 8'h05);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t1_hold_valid", op_valid, 1);
            chk("t1_hold_code", op_code, 4'hA);
            chk("t1_hold_arg", op_arg, 8'h05);
        end
        op_ready = 1'b1;
        step(1);
        op_ready = 1'b0;
        chk("t1_valid_drop", op_valid, 0);
        step(2);
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);

        // JMP skips addresses 1 and 2
        clear_mem();
        mem[0] = 16'h2003; mem[3] = 16'hF000;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            start = 1'b0;
            chk("t2_counter", counter, exp_ctr[i]);
            if (i == 3) chk("t2_done_early", done, 0);
            if (i == 4) chk("t2_done", done, 1);
        end

        // LOOP 3 with an EXEC body
        load_loop_prog();
        repeat (3) sb_q.push_back(12'h100);
        hs_base = hs_cnt;
        op_ready = 1'b1;
        start = 1'b1; step(1); start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            step(1);
        end
        op_ready = 1'b0;
        chk("t3_done", done, 1);
        chk("t3_handshakes", hs_cnt - hs_base, 3);
        chk("t3_sb_empty", sb_q.size(), 0);
        chk("t3_loop_cnt", dut.r_loop_cnt, 0);

        // Illegal opcode at 511, pc wraps to 0
        clear_mem();
        mem[0] = 16'h21FF; mem[511] = 16'h7000;
        start = 1'b1; step(1); start = 1'b0;
        step(1);
        mem[0] = 16'hF000;
        step(1);
        chk("t4_counter_511", counter, 16'h01FF);
        step(2);
        chk("t4_illegal", illegal, 1);
        chk("t4_wrap", counter, 0);
        step(2);
        chk("t4_done", done, 1);
        chk("t4_illegal_sticky", illegal, 1);
        start = 1'b1; step(1); start = 1'b0;
        chk("t4_illegal_clr", illegal, 0);
        step(2);
        chk("t4_done2", done, 1);

        // abort in ISSUE beats a simultaneous start
        mem[0] = 16'h1A05;
        start = 1'b1; step(1); start = 1'b0;
        step(2);
        chk("t5_op_valid", op_valid, 1);
        abort = 1'b1; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t5_valid", op_valid, 0);
        chk("t5_counter", counter, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        start = 1'b1;
        step(1);
        abort = 1'b0; start = 1'b0;
        step(2);
        chk("t5_idle", busy, 0);

        // Asynchronous reset mid-loop
        load_loop_prog();
        repeat (3) sb_q.push_back(12'h100);
        op_ready = 1'b1;
        start = 1'b1; step(1); start = 1'b0;
        step(4);
        chk("t6_pre_valid", op_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_counter", counter, 0);
        chk("t6_valid", op_valid, 0);
        chk("t6_code", op_code, 0);
        chk("t6_arg", op_arg, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_illegal", illegal, 0);
        chk("t6_loop_cnt", dut.r_loop_cnt, 0);
        step(1);
        rst_n = 1'b1; op_ready = 1'b0;
        sb_q.delete();
        step(3);
        chk("t6_stays_idle", busy, 0);
        chk("t6_counter_idle", counter, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Program sequencer directly upstream of the instruction memory: drives its 16-bit `counter` address and consumes its registered 16-bit `instructCode` one cycle later.
- Decodes each instruction and handles NOP, jump, loop and halt locally.
- Hands EXEC micro-ops to the autoencoder datapath controller over a valid/ready handshake.
- Provides start/abort/done control for the top level.

Parameters:
- DATA_WIDTH, 16, instruction word width; must be 16 (encoding below is fixed).
- DEPTH, 512, instruction memory depth in words; pc wraps modulo DEPTH.
- PC_WIDTH, 9, program counter width; must satisfy 2**PC_WIDTH >= DEPTH.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin execution at address 0; honoured only in IDLE or DONE
- abort  in  1  synchronous return to IDLE from any state
- counter  out  16  instruction memory address; pc zero-extended
- instructCode  in  DATA_WIDTH  instruction word; valid the cycle after counter was sampled
- op_valid  out  1  EXEC micro-op available
- op_ready  in  1  datapath accepts micro-op
- op_code  out  4  micro-op code, instr[11:8]
- op_arg  out  8  micro-op argument, instr[7:0]
- busy  out  1  high in FETCH/DECODE/ISSUE
- done  out  1  high in DONE state
- illegal  out  1  sticky flag: undefined opcode decoded; cleared by start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pc=0; loop_cnt=0; all outputs 0 (counter=0, op_valid=0, op_code=0, op_arg=0, busy=0, done=0, illegal=0).
- counter = {16-PC_WIDTH zeros, pc}, driven from the pc register (no combinational path from instructCode).
- Encoding:
  - instr[15:12] = opcode; operand = instr[11:0].
  - 0x0 NOP.
  - 0x1 EXEC.
  - 0x2 JMP (target = operand[PC_WIDTH-1:0]).
  - 0x3 LOOP (loop_cnt = operand).
  - 0x4 DJNZ (target = operand[PC_WIDTH-1:0]).
  - 0xF HALT.
  - All other opcodes: treated as NOP and set illegal.
- States: IDLE, FETCH, DECODE, ISSUE, DONE.
- IDLE / DONE:
  - On start: pc=0, loop_cnt=0, illegal=0, done=0 -> FETCH.
  - start while busy is ignored.
- FETCH: memory samples counter this edge -> DECODE (exactly 1 cycle).
- DECODE: instructCode is valid here. By opcode:
  - NOP / illegal: pc=pc+1 -> FETCH.
  - EXEC: op_code/op_arg registered from instructCode, op_valid=1 -> ISSUE.
  - JMP: pc=target -> FETCH.
  - LOOP: loop_cnt=operand; pc=pc+1 -> FETCH.
  - DJNZ:
    - If loop_cnt > 1: loop_cnt-=1, pc=target.
    - Else: loop_cnt=0, pc=pc+1.
    - Either way -> FETCH. DJNZ with loop_cnt=0 falls through.
  - HALT: done=1 -> DONE; pc holds.
- ISSUE:
  - op_valid, op_code and op_arg are held stable until op_ready=1.
  - Handshake cycle: op_valid=0 next cycle, pc=pc+1 -> FETCH.
  - op_ready while op_valid=0 has no effect.
- Latency:
  - NOP/JMP/LOOP/DJNZ: 2 cycles each.
  - EXEC: 2 cycles + ready wait.
  - start -> first op_valid (EXEC at addr 0): 3 cycles after the start edge.
- pc arithmetic: pc+1 is computed modulo 2**PC_WIDTH; a value >= DEPTH wraps to 0. Operand bits above PC_WIDTH are ignored.
- abort:
  - Has priority over all transitions, including start in the same cycle.
  - Next state IDLE; op_valid=0, done=0, pc=0; loop_cnt and illegal hold.
  - abort during ISSUE with op_ready=1 in the same cycle: the handshake is considered completed by the datapath, but the sequencer still goes to IDLE.
- Reset mid-operation: immediate return to reset values regardless of state.

Decomposition:
- Shared package `autoenc_pkg`: opcode constants (OP_NOP, OP_EXEC, OP_JMP, OP_LOOP, OP_DJNZ, OP_HALT), state encoding localparams, and field bit positions.
- No sub-module required. The pc/loop-counter datapath and FSM fit in one module. An optional `loop_counter` sub-module is acceptable but not mandated.

Test Plan:
- Reset then start with program {0x1A05, 0xF000} -> op_valid at cycle 3 with op_code=0xA, op_arg=0x05; op_ready held 0 for 4 cycles keeps outputs stable; after accept, done=1 two cycles later and busy=0.
- Program {0x2003, 0x0000, 0x0000, 0xF000} -> counter sequence 0,3 (addresses 1-2 never presented); done=1 at cycle 5 after start.
- Loop: {0x3003, 0x1100, 0x4001, 0xF000} -> exactly 3 EXEC handshakes (op_arg=0x00, op_code=0x1), then HALT; loop_cnt=0 at end.
- Illegal and wrap: addr 511 = 0x7000, addr 0 = 0xF000, entered via JMP 0x1FF -> illegal=1; pc wraps to 0; done=1; next start clears illegal.
- abort asserted in ISSUE with op_ready=0 -> next cycle IDLE, op_valid=0, counter=0; start in the same cycle as abort is ignored.
- rst_n pulsed low mid-loop -> all outputs 0 asynchronously (before the next clock edge); state stays IDLE until start.
